// File: rtl/cart_loader_pkg.sv
// rtl/cart_loader_pkg.sv - shared types and constants for the cartridge download stage
package cart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_FINISH
  } state_t;

  localparam logic [4:0]  SG_INDEX  = 5'd2;
  localparam logic [19:0] EXTRAM_LO = 20'h02000;
  localparam logic [19:0] EXTRAM_HI = 20'h03FFF;

  localparam logic [15:0] HDR_AA55 = 16'hAA55;
  localparam logic [15:0] HDR_55AA = 16'h55AA;

endpackage

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - serialises HPS download bytes into SDRAM writes and derives cart metadata
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int         MAX_ABITS = 20,
  parameter logic [4:0] SG_INDEX  = cart_loader_pkg::SG_INDEX
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  output logic [MAX_ABITS-1:0]  mem_addr,
  output logic [7:0]            mem_din,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [MAX_ABITS-15:0] cart_pages,
  output logic                  sg1000,
  output logic                  extram,
  output logic                  hdr_ok,
  output logic                  size_err,
  output logic                  overrun,
  output logic                  load_done
);

  state_t state_q, state_d;

  logic [7:0] h0;
  logic       cand;
  logic       seen_end;
  logic       fall_seen;

  logic                  in_range;
  logic                  wr_accept;
  logic [19:0]           addr_lo;
  logic [MAX_ABITS-15:0] page;
  logic                  unused_index;

  assign in_range     = (ioctl_addr[24:MAX_ABITS] == '0);
  assign wr_accept    = (state_q == ST_LOAD) && ioctl_wr && in_range;
  assign addr_lo      = ioctl_addr[19:0];
  assign page         = ioctl_addr[MAX_ABITS-1:14];
  assign unused_index = ^ioctl_index[7:5];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A download that ends while a write is stalled finishes straight from WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ioctl_download) state_d = ST_LOAD;
      ST_LOAD: begin
        if (wr_accept)            state_d = ST_WRITE;
        else if (!ioctl_download) state_d = ST_FINISH;
      end
      ST_WRITE: begin
        if (mem_ready) state_d = (fall_seen || !ioctl_download) ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      cart_pages <= '0;
      sg1000     <= 1'b0;
      extram     <= 1'b0;
      hdr_ok     <= 1'b0;
      size_err   <= 1'b0;
      overrun    <= 1'b0;
      load_done  <= 1'b0;
      h0         <= '0;
      cand       <= 1'b0;
      seen_end   <= 1'b0;
      fall_seen  <= 1'b0;
    end else begin
      load_done <= (state_d == ST_FINISH);
      if (state_d == ST_FINISH) extram <= sg1000 & cand & seen_end;

      case (state_q)
        ST_IDLE: begin
          if (ioctl_download) begin
            size_err   <= 1'b0;
            overrun    <= 1'b0;
            cart_pages <= '0;
            hdr_ok     <= 1'b0;
            extram     <= 1'b0;
            h0         <= '0;
            cand       <= 1'b0;
            seen_end   <= 1'b0;
            fall_seen  <= 1'b0;
            sg1000     <= (ioctl_index[4:0] == SG_INDEX);
          end
        end
        ST_LOAD: begin
          if (ioctl_wr && !in_range) size_err <= 1'b1;
          if (wr_accept) begin
            mem_addr   <= ioctl_addr[MAX_ABITS-1:0];
            mem_din    <= ioctl_dout;
            mem_we     <= 1'b1;
            ioctl_wait <= 1'b1;
            fall_seen  <= !ioctl_download;
            if (page > cart_pages) cart_pages <= page;
            if (addr_lo == 20'd0) h0 <= ioctl_dout;
            if (addr_lo == 20'd1)
              hdr_ok <= ({h0, ioctl_dout} == HDR_AA55) || ({h0, ioctl_dout} == HDR_55AA);
            // Extra RAM is inferred only if the whole 8 KiB window reads back as FF.
            if (sg1000) begin
              if (addr_lo == EXTRAM_LO)
                cand <= (ioctl_dout == 8'hFF);
              else if (addr_lo > EXTRAM_LO && addr_lo <= EXTRAM_HI)
                cand <= cand & (ioctl_dout == 8'hFF);
              if (addr_lo == EXTRAM_HI) seen_end <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (ioctl_wr)        overrun   <= 1'b1;
          if (!ioctl_download) fall_seen <= 1'b1;
          if (mem_ready) begin
            mem_we     <= 1'b0;
            ioctl_wait <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - randomized self-checking bench for cart_loader
module tb_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        mem_ready;
  logic        ioctl_wait;
  logic [19:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [5:0]  cart_pages;
  logic        sg1000, extram, hdr_ok, size_err, overrun, load_done;

  cart_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_ready(mem_ready),
    .cart_pages(cart_pages), .sg1000(sg1000), .extram(extram), .hdr_ok(hdr_ok),
    .size_err(size_err), .overrun(overrun), .load_done(load_done)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  int         ready_mode = 0;
  logic       ready_force = 1'b1;

  logic [27:0] exp_arr [0:65535];
  logic [27:0] act_arr [0:65535];
  int          wr_expected = 0;
  int          wr_chk = 0;
  int          wr_seen = 0;
  int          ld_count = 0;
  int          ld_base = 0;

  logic [7:0] img [int];
  int         pages_exp;
  logic       sg_exp, size_exp, over_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM acceptance: always ready, random stalls, or bench-forced level.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk_sys);
      #2;
      if (ready_mode == 0)      mem_ready = 1'b1;
      else if (ready_mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
      else                      mem_ready = ready_force;
    end
  end

  always @(negedge clk_sys) begin
    if (!reset && mem_we && mem_ready) begin
      act_arr[wr_seen] = {mem_addr, mem_din};
      wr_seen++;
    end
    if (!reset && load_done) ld_count++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got cycle budget exhausted, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    if (ioctl_wait) check_eq("drain_timeout", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic model_record(input logic [24:0] a, input logic [7:0] d);
    if (a[24:20] != 5'd0) begin
      size_exp = 1'b1;
    end else begin
      exp_arr[wr_expected] = {a[19:0], d};
      wr_expected++;
      img[int'(a[19:0])] = d;
      if (int'(a[19:14]) > pages_exp) pages_exp = int'(a[19:14]);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    repeat (gap) tick();
    drain();
    model_record(a, d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic begin_load(input logic [7:0] idx);
    img.delete();
    pages_exp = 0;
    sg_exp    = (idx[4:0] == 5'd2);
    size_exp  = 1'b0;
    over_exp  = 1'b0;
    ld_base   = ld_count;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    check_eq("start_clear", 32'({size_err, overrun, hdr_ok, extram, cart_pages}), 32'd0);
    check_eq("sg1000_latch", 32'(sg1000), 32'(sg_exp));
  endtask

  task automatic check_stream();
    check_eq("write_count", 32'(wr_seen), 32'(wr_expected));
    for (int i = wr_chk; i < wr_expected && i < wr_seen; i++)
      check_eq("wr_stream", 32'(act_arr[i]), 32'(exp_arr[i]));
    wr_chk = wr_expected;
  endtask

  task automatic finish_checks();
    logic [15:0] h;
    logic        hdr_e, all_ff, ext_e;
    hdr_e = 1'b0;
    if (img.exists(0) && img.exists(1)) begin
      h = {img[0], img[1]};
      hdr_e = (h == 16'hAA55) || (h == 16'h55AA);
    end
    all_ff = 1'b1;
    for (int k = 'h2000; k <= 'h3FFF; k++)
      if (img.exists(k) && img[k] != 8'hFF) all_ff = 1'b0;
    ext_e = sg_exp && img.exists('h2000) && img.exists('h3FFF) && all_ff;
    check_eq("cart_pages", 32'(cart_pages), 32'(pages_exp));
    check_eq("hdr_ok", 32'(hdr_ok), 32'(hdr_e));
    check_eq("extram", 32'(extram), 32'(ext_e));
    check_eq("sg1000", 32'(sg1000), 32'(sg_exp));
    check_eq("size_err", 32'(size_err), 32'(size_exp));
    check_eq("overrun", 32'(overrun), 32'(over_exp));
    tick();
    check_eq("load_done_width", 32'(load_done), 32'd0);
    check_eq("load_done_count", 32'(ld_count - ld_base), 32'd1);
    check_stream();
  endtask

  task automatic end_load();
    drain();
    ioctl_download = 1'b0;
    tick();
    check_eq("load_done_rise", 32'(load_done), 32'd1);
    finish_checks();
  endtask

  task automatic sg_test(input int mode);
    int a;
    ready_mode = 0;
    begin_load(8'h02);
    a = 0;
    while (a < 'h2000) begin
      send_byte(25'(a), 8'($urandom), 0);
      a += $urandom_range(1, 64);
    end
    if (mode < 2) begin
      for (int k = 'h2000; k <= 'h3FFF; k++)
        send_byte(25'(k), (mode == 1 && k == 'h2ABC) ? 8'h00 : 8'hFF, 0);
      a = 'h4000;
      while (a < 'hBFFF) begin
        send_byte(25'(a), 8'($urandom), 0);
        a += $urandom_range(1, 32);
      end
      send_byte(25'h0BFFF, 8'($urandom), 0);
    end else begin
      for (int k = 'h2000; k <= 'h27FF; k++) send_byte(25'(k), 8'hFF, 0);
    end
    end_load();
  endtask

  task automatic rand_load();
    int          a, lim;
    logic [15:0] hdr;
    logic [7:0]  idx;
    idx = {3'($urandom), 5'($urandom_range(0, 3))};
    ready_mode = 1;
    begin_load(idx);
    case ($urandom_range(0, 2))
      0:       hdr = 16'hAA55;
      1:       hdr = 16'h55AA;
      default: hdr = 16'($urandom);
    endcase
    send_byte(25'd0, hdr[15:8], $urandom_range(0, 2));
    send_byte(25'd1, hdr[7:0], $urandom_range(0, 2));
    lim = $urandom_range('h4000, 'hFFFFF);
    a = 2;
    while (a <= lim) begin
      if ($urandom_range(0, 15) == 0)
        send_byte({5'($urandom_range(1, 31)), 20'($urandom)}, 8'($urandom), 0);
      send_byte(25'(a), 8'($urandom), $urandom_range(0, 2));
      a += $urandom_range(1, 4096);
    end
    end_load();
    ready_mode = 0;
  endtask

  initial begin
    logic [15:0] hdr;
    int          a;
    int          we_cyc, wait_cyc;

    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("rst_mem", 32'({mem_addr, mem_din, mem_we}), 32'd0);
    check_eq("rst_flags", 32'({ioctl_wait, cart_pages, sg1000, extram, hdr_ok, size_err, overrun, load_done}), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_flags", 32'({ioctl_wait, mem_we, cart_pages, sg1000, extram, hdr_ok, size_err, overrun, load_done}), 32'd0);

    // Coleco 32 KiB image with the SDRAM always ready
    ready_mode = 0;
    begin_load(8'h00);
    hdr = ($urandom_range(0, 1) != 0) ? 16'hAA55 : 16'h55AA;
    send_byte(25'd0, hdr[15:8], 0);
    check_eq("we_latency", 32'({ioctl_wait, mem_we}), 32'd3);
    check_eq("mem_din_0", 32'(mem_din), 32'(hdr[15:8]));
    tick();
    check_eq("we_single", 32'(mem_we), 32'd0);
    send_byte(25'd1, hdr[7:0], 0);
    check_eq("hdr_ok_latency", 32'(hdr_ok), 32'd1);
    a = 2;
    while (a < 'h7FFF) begin
      send_byte(25'(a), 8'($urandom), 0);
      a += $urandom_range(1, 24);
    end
    send_byte(25'h07FFF, 8'($urandom), 0);
    end_load();

    // stalled write with an overrun strobe, then an oversize byte
    begin_load(8'h01);
    send_byte(25'd0, 8'($urandom), 0);
    send_byte(25'h05000, 8'($urandom), 0);
    drain();
    ready_force = 1'b0;
    ready_mode  = 2;
    send_byte(25'h01234, 8'($urandom), 0);
    we_cyc = 0;
    wait_cyc = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_we) we_cyc++;
      if (ioctl_wait) wait_cyc++;
      if (c == 2) begin
        ioctl_addr = 25'h01300;
        ioctl_dout = 8'h5A;
        ioctl_wr   = 1'b1;
        over_exp   = 1'b1;
      end
      tick();
      ioctl_wr = 1'b0;
    end
    ready_force = 1'b1;
    if (mem_we) we_cyc++;
    if (ioctl_wait) wait_cyc++;
    check_eq("stall_addr", 32'(mem_addr), 32'h01234);
    tick();
    check_eq("stall_we_cycles", 32'(we_cyc), 32'd6);
    check_eq("stall_wait_cycles", 32'(wait_cyc), 32'd6);
    check_eq("stall_release", 32'({mem_we, ioctl_wait}), 32'd0);
    check_eq("overrun_set", 32'(overrun), 32'(over_exp));
    ready_mode = 0;
    send_byte(25'h100000, 8'($urandom), 0);
    check_eq("size_no_we", 32'({mem_we, ioctl_wait}), 32'd0);
    check_eq("size_err_set", 32'(size_err), 32'(size_exp));
    check_eq("size_pages", 32'(cart_pages), 32'(pages_exp));
    end_load();

    sg_test(0);
    sg_test(1);
    sg_test(2);

    for (int r = 0; r < 3; r++) rand_load();

    // download ends while a write is stalled
    ready_mode = 0;
    begin_load(8'h00);
    send_byte(25'd0, 8'hAA, 0);
    send_byte(25'd1, 8'h55, 0);
    drain();
    ready_force = 1'b0;
    ready_mode  = 2;
    send_byte(25'h00042, 8'($urandom), 0);
    ioctl_download = 1'b0;
    tick();
    tick();
    check_eq("fall_we_held", 32'(mem_we), 32'd1);
    check_eq("fall_no_done", 32'(load_done), 32'd0);
    ready_force = 1'b1;
    tick();
    check_eq("fall_we_done", 32'(mem_we), 32'd0);
    check_eq("fall_load_done", 32'(load_done), 32'd1);
    ready_mode = 0;
    finish_checks();

    // asynchronous reset in the middle of a stalled write
    begin_load(8'h02);
    send_byte(25'd0, 8'hAA, 0);
    send_byte(25'd1, 8'h55, 0);
    drain();
    ready_force = 1'b0;
    ready_mode  = 2;
    send_byte(25'h04000, 8'($urandom), 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_mem", 32'({mem_addr, mem_din, mem_we}), 32'd0);
    check_eq("async_rst_flags", 32'({ioctl_wait, cart_pages, sg1000, extram, hdr_ok, size_err, overrun, load_done}), 32'd0);
    ioctl_download = 1'b0;
    wr_expected--;
    tick();
    tick();
    reset = 1'b0;
    ready_mode = 0;
    repeat (3) tick();
    check_eq("post_rst_flags", 32'({ioctl_wait, mem_we, cart_pages, sg1000, extram, hdr_ok, load_done}), 32'd0);
    check_eq("post_rst_no_done", 32'(ld_count - ld_base), 32'd0);
    check_stream();

    rand_load();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
# cart_loader

Cartridge download stage between the HPS file-transfer stream (`ioctl_*`) and the SDRAM cartridge store. It sits directly upstream of the console core. It serialises each downloaded byte into a backpressured SDRAM write and derives the load-time metadata the console consumes:

- page count (`cart_pages`)
- SG-1000 mode flag
- SG-1000 extra-RAM flag
- ColecoVision header validity
- error flags

## Interface
Parameters:
- `MAX_ABITS`, default 20: cartridge address width; images are limited to 1 MiB.
- `SG_INDEX`, default 5'd2: value of `ioctl_index[4:0]` that selects SG-1000 mode.

Ports:
- `clk_sys`  in  1  system clock. This is the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  high for the whole duration of a file transfer.
- `ioctl_index`  in  8  file-type index; only bits [4:0] are used.
- `ioctl_wr`  in  1  single-cycle byte strobe.
- `ioctl_addr`  in  25  byte address of the current strobe.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  backpressure to the HPS; while high, the HPS issues no `ioctl_wr`.
- `mem_addr`  out  20  SDRAM write address.
- `mem_din`  out  8  SDRAM write data.
- `mem_we`  out  1  write request, held until accepted.
- `mem_ready`  in  1  SDRAM acceptance of the pending write.
- `cart_pages`  out  6  highest 16 KiB page index written.
- `sg1000`  out  1  SG-1000 mode.
- `extram`  out  1  SG-1000 image has 0x2000–0x3FFF entirely 0xFF, i.e. RAM is mapped there.
- `hdr_ok`  out  1  first two bytes are AA 55 or 55 AA.
- `size_err`  out  1  a byte at address ≥ 1 MiB was seen.
- `overrun`  out  1  an `ioctl_wr` arrived while `ioctl_wait` was high.
- `load_done`  out  1  one-cycle pulse when the load completes.

## Operation
Reset values: every output is 0.

State machine states: IDLE, LOAD, WRITE, FINISH.

- IDLE → LOAD on `ioctl_download` = 1. On this transition:
  - clear `size_err`, `overrun` and the internal flags;
  - latch `sg1000` ← (`ioctl_index[4:0]` == `SG_INDEX`).
- LOAD, on `ioctl_wr`:
  - If `ioctl_addr[24:20]` ≠ 0: set `size_err`, drop the byte, stay in LOAD.
  - Otherwise: latch `mem_addr` ← `ioctl_addr[19:0]` and `mem_din` ← `ioctl_dout`; assert `mem_we` and `ioctl_wait`; go to WRITE.
  - Metadata is updated on the same accepted strobe:
    - `cart_pages` ← max(`cart_pages`, `addr[19:14]`).
    - At addr 0, `h0` ← `dout`. At addr 1, `hdr_ok` ← ({`h0`, `dout`} ∈ {AA55, 55AA}).
    - When `sg1000`: at addr 0x2000, `cand` ← (`dout` == FF). At 0x2001–0x3FFF, `cand` ← `cand` & (`dout` == FF). At addr 0x3FFF, set `seen_end`.
- LOAD → FINISH when `ioctl_download` falls.
- WRITE:
  - `mem_we` stays high until a cycle with `mem_ready` = 1.
  - In that cycle the write completes; on the next edge `mem_we` = 0, `ioctl_wait` = 0, and the state returns to LOAD.
  - An `ioctl_wr` arriving in WRITE sets `overrun`; the byte is discarded and no metadata is updated.
  - A falling `ioctl_download` in WRITE is remembered; the pending write still completes, then the FSM goes directly to FINISH.
- FINISH, lasting one cycle:
  - `extram` ← `sg1000` & `cand` & `seen_end`;
  - pulse `load_done`;
  - go to IDLE.
- Metadata outputs hold their values until the next download starts.
- Asynchronous reset at any point returns to IDLE immediately with all outputs 0. A write in progress is abandoned.

## Timing
- Latency from `ioctl_wr` to `mem_we`/`ioctl_wait` high is 1 cycle (registered).
- Write acceptance: if `mem_ready` is already high, `mem_we` is high for exactly 1 cycle. Minimum spacing between accepted strobes is therefore 2 cycles.
- `load_done` rises 1 cycle after `ioctl_download` falls, or 1 cycle after the final write completes if a write was pending. It is high for 1 cycle.
- `extram` updates in the same cycle as `load_done`. `cart_pages` and `hdr_ok` update 1 cycle after their strobe.
- A simultaneous `ioctl_wr` and `ioctl_download` fall in LOAD: the byte is written, then the FSM goes to FINISH.

## Structure
- Package `cart_loader_pkg` holds:
  - the state enum;
  - `SG_INDEX`;
  - `EXTRAM_LO` = 0x2000 and `EXTRAM_HI` = 0x3FFF;
  - the header constants AA55 and 55AA.
- The block is a single module; no sub-module.

## Test plan
- Coleco image of 32 KiB with bytes AA 55…, `mem_ready` tied to 1 → 32768 single-cycle writes; `cart_pages` = 1; `hdr_ok` = 1; `sg1000` = 0; one `load_done` pulse.
- SG-1000 image (index 2) of 48 KiB with 0x2000–0x3FFF all FF → `extram` = 1 at `load_done`. Repeat with byte 0x2ABC = 00 → `extram` = 0. Repeat with a 10 KiB file → `extram` = 0 because `seen_end` = 0.
- `mem_ready` held low for 5 cycles on the byte at addr 0x1234 → `mem_we` and `ioctl_wait` stay high for 6 cycles; `mem_addr` = 0x01234. An injected `ioctl_wr` during the stall → `overrun` = 1 and no extra write.
- Byte at `ioctl_addr` 0x100000 → no `mem_we`; `size_err` = 1; `cart_pages` unchanged.
- `ioctl_download` falls while a write is stalled → the write completes first, then `load_done` follows 1 cycle later. `reset` pulsed mid-WRITE → all outputs 0 asynchronously and the state returns to IDLE.
